// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the sequential add/subtract controller: FSM states,
// slice width and the carry-lookahead helper used by the 8-bit slice adder.
package add_seq_ctrl_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry into bit (pos+1): sum of products of generate terms and the
    // input carry, each gated by every propagate above it (flat lookahead).
    function automatic logic cla_carry(
        input logic [SLICE_W-1:0] g,
        input logic [SLICE_W-1:0] p,
        input logic               cin,
        input int                 pos
    );
        logic c;
        logic prod;
        c = 1'b0;
        for (int j = -1; j <= pos; j++) begin
            prod = (j < 0) ? cin : g[j];
            for (int k = j + 1; k <= pos; k++) begin
                prod = prod & p[k];
            end
            c = c | prod;
        end
        return c;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_cla.sv
// 8-bit carry-lookahead slice adder (cla_8_bit): purely combinational,
// every internal carry derived directly from generate/propagate terms.
module cla_8_bit
    import add_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               cout_o
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g    = a_i & b_i;
    assign p    = a_i ^ b_i;
    assign c[0] = cin_i;

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_carry
            assign c[gi+1] = cla_carry(g, p, cin_i, gi);
            assign s_o[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign cout_o = c[SLICE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// WIDTH-bit add/subtract sequencer: one 8-bit CLA slice per clock, LSB first.
// Define ADD_SEQ_OVF_EN to add the signed-overflow output out_ovf.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef ADD_SEQ_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int SLICES = WIDTH / SLICE_W;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;

    logic               accept;
    logic               run;
    logic               last_slice;
    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] s_slice;
    logic               cout_slice;

    logic [SLICE_W-1:0] a_parts [SLICES];
    logic [SLICE_W-1:0] b_parts [SLICES];

    // Slice views of the latched operands, selected by the running index.
    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_parts
            assign a_parts[gi] = a_q[gi*SLICE_W +: SLICE_W];
            assign b_parts[gi] = b_q[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign a_slice = a_parts[idx_q];
    assign b_slice = b_parts[idx_q];

    cla_8_bit u_cla (
        .a_i    (a_slice),
        .b_i    (b_slice),
        .cin_i  (carry_q),
        .s_o    (s_slice),
        .cout_o (cout_slice)
    );

    assign accept     = (state_q == ST_IDLE) && in_valid;
    assign run        = (state_q == ST_RUN);
    assign last_slice = run && (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy    = 1'b0;
            end
        endcase
    end

    // Datapath next-state: operands are captured only on accept.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        if (accept) begin
            a_d     = in_a;
            b_d     = in_b ^ {WIDTH{in_sub}};
            carry_d = in_sub;
            idx_d   = '0;
        end else if (run) begin
            carry_d = cout_slice;
            idx_d   = last_slice ? '0 : idx_q + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_sum
            always_comb begin
                sum_d[gi*SLICE_W +: SLICE_W] = sum_q[gi*SLICE_W +: SLICE_W];
                if (accept) begin
                    sum_d[gi*SLICE_W +: SLICE_W] = '0;
                end else if (run && (idx_q == IDX_W'(gi))) begin
                    sum_d[gi*SLICE_W +: SLICE_W] = s_slice;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = carry_q;

`ifdef ADD_SEQ_OVF_EN
    logic ovf_q, ovf_d;
    logic c_msb;

    // Carry into the MSB recovered from the top bit's operands and sum.
    assign c_msb = a_slice[SLICE_W-1] ^ b_slice[SLICE_W-1] ^ s_slice[SLICE_W-1];

    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (last_slice) begin
            ovf_d = c_msb ^ cout_slice;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl (32-bit), with overflow
// checks enabled when ADD_SEQ_OVF_EN is defined.
module tb_add_seq_ctrl;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef ADD_SEQ_OVF_EN
    logic             out_ovf;
`endif
    logic             busy;

    int errors = 0;
    int checks = 0;

    add_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef ADD_SEQ_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept one op, then wait (bounded) for out_valid and check latency.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sub, input string tag);
        int n;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        $display("op %s: a=%08h b=%08h sub=%0b -> sum=%08h cout=%0b", tag, a, b, sub, out_sum, out_cout);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(out_sum), 64'd0);
        check("rst_cout", 64'(out_cout), 64'd0);
`ifdef ADD_SEQ_OVF_EN
        check("rst_ovf", 64'(out_ovf), 64'd0);
`endif
        reset_n = 1'b1;
        tick();
        check("rst_ready", 64'(in_ready), 64'd1);

        // 1. Reset mid-RUN drops the op
        in_a = 32'h0000_00FF; in_b = 32'h0000_0001; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(out_sum), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_valid2", 64'(out_valid), 64'd0);
        $display("op reset_mid_run: sum=%08h valid=%0b", out_sum, out_valid);

        // 2. Full carry ripple
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "ripple");
        check("ripple_sum", 64'(out_sum), 64'h0000_0000);
        check("ripple_cout", 64'(out_cout), 64'd1);
        check("ripple_busy", 64'(busy), 64'd1);
        finish_op("ripple");

        // 3. Subtract both directions
        start_op(32'h0000_0005, 32'h0000_0007, 1'b1, "sub57");
        check("sub57_sum", 64'(out_sum), 64'hFFFF_FFFE);
        check("sub57_cout", 64'(out_cout), 64'd0);
        finish_op("sub57");
        start_op(32'h0000_0007, 32'h0000_0005, 1'b1, "sub75");
        check("sub75_sum", 64'(out_sum), 64'h0000_0002);
        check("sub75_cout", 64'(out_cout), 64'd1);
        finish_op("sub75");
        check("idle_holds_sum", 64'(out_sum), 64'h0000_0002);

        // 4. Backpressure: result held, no accept while held
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_sum", 64'(out_sum), 64'h2345_6789);
            check("bp_cout", 64'(out_cout), 64'd0);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        finish_op("bp");

`ifdef ADD_SEQ_OVF_EN
        // 5. Signed overflow
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "ovf_add");
        check("ovf_add_sum", 64'(out_sum), 64'h8000_0000);
        check("ovf_add_ovf", 64'(out_ovf), 64'd1);
        finish_op("ovf_add");
        start_op(32'h8000_0000, 32'h0000_0001, 1'b1, "ovf_sub");
        check("ovf_sub_sum", 64'(out_sum), 64'h7FFF_FFFF);
        check("ovf_sub_ovf", 64'(out_ovf), 64'd1);
        check("ovf_sub_cout", 64'(out_cout), 64'd1);
        finish_op("ovf_sub");
        start_op(32'h0000_0001, 32'h0000_0001, 1'b0, "no_ovf");
        check("no_ovf_sum", 64'(out_sum), 64'h0000_0002);
        check("no_ovf_ovf", 64'(out_ovf), 64'd0);
        finish_op("no_ovf");
`endif

        // 6. Operands changed after accept, in_valid held through DONE
        in_a = 32'h0000_0003; in_b = 32'h0000_0004; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_a = 32'hAAAA_0000; in_b = 32'h0000_5555; in_sub = 1'b1;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                check("hold_in_ready", 64'(in_ready), 64'd0);
                tick();
                n++;
            end
            check("hold_latency", 64'(n), 64'd4);
        end
        for (int i = 0; i < 3; i++) begin
            check("hold_sum", 64'(out_sum), 64'h0000_0007);
            check("hold_done_ready", 64'(in_ready), 64'd0);
            tick();
        end
        $display("op latched_operands: sum=%08h cout=%0b", out_sum, out_cout);
        in_valid = 1'b0;
        finish_op("hold");
        check("hold_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
